// File: rtl/ahb_arb_pkg.sv
// ============================================================================
// Module      : ahb_arb_pkg
// Description : Shared types and constants for the two-master AHB arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef logic mst_idx_t;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [0:0] {
        ST_PARK = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    function automatic logic [NUM_MASTERS-1:0] onehot(input mst_idx_t idx);
        logic [NUM_MASTERS-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_arb_rr_pick.sv
// ============================================================================
// Module      : ahb_arb_rr_pick
// Description : Combinational round-robin winner for two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_arb_rr_pick
    import ahb_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  mst_idx_t               last_i,
    output mst_idx_t               winner_o,
    output logic                   contended_o
);

    always_comb begin
        contended_o = &req_i;
        winner_o    = last_i;
        if (contended_o) begin
            winner_o = ~last_i;
        end else if (req_i[1]) begin
            winner_o = 1'b1;
        end else if (req_i[0]) begin
            winner_o = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ahb_arbiter.sv
// ============================================================================
// Module      : ahb_arbiter
// Description : Two-master round-robin AHB arbiter with bus parking and
//               address/data-phase muxing. Optional tenure limit enabled by
//               defining ARB_TENURE_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_TENURE     = 16,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic [1:0]        hbusreq,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic [1:0]        m1_htrans,
    input  logic              m0_hwrite,
    input  logic              m1_hwrite,
    input  logic [DATA_W-1:0] m0_hwdata,
    input  logic [DATA_W-1:0] m1_hwdata,
    input  logic              hready_in,
    output logic [1:0]        hgrant,
    output logic              hmaster,
    output logic              hmaster_d,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [DATA_W-1:0] hwdata
);

    localparam mst_idx_t c_DEF_MST = DEFAULT_MASTER[0];

    arb_state_e state_q, state_d;
    mst_idx_t   grant_idx_q, grant_idx_d;
    mst_idx_t   rr_last_q, rr_last_d;
    mst_idx_t   hmaster_q;
    mst_idx_t   dphase_q;

    logic       w_owner_req;
    logic       w_other_req;
    logic [1:0] w_owner_trans;
    logic       w_expire;
    logic       w_arb;
    mst_idx_t   w_rr_in;
    mst_idx_t   w_winner;
    logic       w_contended;

    assign w_owner_req   = hbusreq[grant_idx_q];
    assign w_other_req   = hbusreq[~grant_idx_q];
    assign w_owner_trans = grant_idx_q ? m1_htrans : m0_htrans;

`ifdef ARB_TENURE_LIMIT_EN
    localparam int c_TW = $clog2(MAX_TENURE + 1);

    logic [c_TW-1:0] tenure_q, tenure_d;

    assign w_expire = (tenure_q == c_TW'(MAX_TENURE));

    always_comb begin
        tenure_d = tenure_q + 1'b1;
        if (state_q != ST_OWN || !w_other_req || grant_idx_d != grant_idx_q) begin
            tenure_d = '0;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            tenure_q <= '0;
        end else if (hready_in) begin
            tenure_q <= tenure_d;
        end
    end
`else
    localparam int c_UNUSED_TENURE = MAX_TENURE;

    assign w_expire = 1'b0;
`endif

    assign w_arb = (state_q == ST_PARK) || !w_owner_req ||
                   (w_owner_trans == HTRANS_IDLE) || w_expire;

    // On tenure expiry the owner is treated as the last winner so the
    // contending master is guaranteed to take over.
    assign w_rr_in = w_expire ? grant_idx_q : rr_last_q;

    ahb_arb_rr_pick u_rr_pick (
        .req_i       (hbusreq),
        .last_i      (w_rr_in),
        .winner_o    (w_winner),
        .contended_o (w_contended)
    );

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_last_d   = rr_last_q;
        if (w_arb) begin
            if (hbusreq == '0) begin
                state_d     = ST_PARK;
                grant_idx_d = c_DEF_MST;
            end else begin
                state_d     = ST_OWN;
                grant_idx_d = w_winner;
                if (w_contended) begin
                    rr_last_d = w_winner;
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_PARK;
            grant_idx_q <= c_DEF_MST;
            rr_last_q   <= c_DEF_MST;
            hmaster_q   <= c_DEF_MST;
            dphase_q    <= c_DEF_MST;
        end else if (hready_in) begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_last_q   <= rr_last_d;
            hmaster_q   <= grant_idx_q;
            dphase_q    <= hmaster_q;
        end
    end

    assign hgrant    = onehot(grant_idx_q);
    assign hmaster   = hmaster_q;
    assign hmaster_d = dphase_q;

    assign haddr  = hmaster_q ? m1_haddr  : m0_haddr;
    assign htrans = hmaster_q ? m1_htrans : m0_htrans;
    assign hwrite = hmaster_q ? m1_hwrite : m0_hwrite;
    assign hwdata = dphase_q  ? m1_hwdata : m0_hwdata;

endmodule

`default_nettype wire
